// File: rtl/nw_ctrl_fsm_if.sv
// Handshake/bus bundle between the Needleman-Wunsch control FSM and its
// surroundings (start logic, scoring datapath, score-matrix RAM).
interface nw_ctrl_fsm_if #(
  parameter int LEN_W  = 4,
  parameter int N_READ = 4
);
  localparam int RS_W = (N_READ > 1) ? $clog2(N_READ) : 1;

  // Requests and datapath status towards the FSM
  logic             start;
  logic [LEN_W-1:0] len_a;
  logic [LEN_W-1:0] len_b;
  logic             tb_en;
  logic             calculated;
  logic [1:0]       tb_dir;
  logic             abort;

  // Control and status from the FSM
  logic             we;
  logic             en_init;
  logic             en_ins;
  logic             en_read;
  logic             en_traceB;
  logic             change_index;
  logic [2:0]       state;
  logic [LEN_W-1:0] i;
  logic [LEN_W-1:0] j;
  logic [RS_W-1:0]  rd_sel;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, len_a, len_b, tb_en, calculated, tb_dir, abort,
    input  we, en_init, en_ins, en_read, en_traceB, change_index,
           state, i, j, rd_sel, busy, done, err
  );

  modport slave (
    input  start, len_a, len_b, tb_en, calculated, tb_dir, abort,
    output we, en_init, en_ins, en_read, en_traceB, change_index,
           state, i, j, rd_sel, busy, done, err
  );
endinterface

// File: rtl/nw_ctrl_fsm.sv
// Control FSM for the Needleman-Wunsch datapath: matrix init, per-cell
// neighbour-read/fill loop and traceback, with cell and read-slot counters.
module nw_ctrl_fsm #(
  parameter int LEN_W  = 4,
  parameter int N_READ = 4
) (
  input  logic          clk,
  input  logic          rst,
  nw_ctrl_fsm_if.slave  bus
);

  localparam int RS_W = (N_READ > 1) ? $clog2(N_READ) : 1;

  localparam logic [RS_W-1:0]  RD_ZERO  = RS_W'(0);
  localparam logic [RS_W-1:0]  RD_ONE   = RS_W'(1);
  localparam logic [RS_W-1:0]  RD_LAST  = RS_W'(N_READ - 1);
  localparam logic [LEN_W-1:0] IDX_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] IDX_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_READ    = 3'd2,
    S_CHANGE  = 3'd3,
    S_FILLING = 3'd4,
    S_TRACE_B = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t           state_q,  state_d;
  logic [LEN_W-1:0] i_q,      i_d;
  logic [LEN_W-1:0] j_q,      j_d;
  logic [RS_W-1:0]  rd_q,     rd_d;
  logic [LEN_W-1:0] len_a_q,  len_a_d;
  logic [LEN_W-1:0] len_b_q,  len_b_d;
  logic             tb_en_q,  tb_en_d;
  logic             err_q,    err_d;

  logic we_s, en_init_s, en_ins_s, en_read_s, en_traceb_s, change_s, busy_s, done_s;

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= IDX_ZERO;
      j_q     <= IDX_ZERO;
      rd_q    <= RD_ZERO;
      len_a_q <= IDX_ZERO;
      len_b_q <= IDX_ZERO;
      tb_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rd_q    <= rd_d;
      len_a_q <= len_a_d;
      len_b_q <= len_b_d;
      tb_en_q <= tb_en_d;
      err_q   <= err_d;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    rd_d    = rd_q;
    len_a_d = len_a_q;
    len_b_d = len_b_q;
    tb_en_d = tb_en_q;
    err_d   = 1'b0;

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if ((bus.len_a != IDX_ZERO) && (bus.len_b != IDX_ZERO)) begin
              state_d = S_INIT;
              len_a_d = bus.len_a;
              len_b_d = bus.len_b;
              tb_en_d = bus.tb_en;
              i_d     = IDX_ZERO;
              j_d     = IDX_ZERO;
              rd_d    = RD_ZERO;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        // Row 0 first, then column 0 from row 1 down to len_a
        S_INIT: begin
          if ((i_q == IDX_ZERO) && (j_q != len_b_q)) begin
            j_d = j_q + IDX_ONE;
          end else if (i_q == IDX_ZERO) begin
            i_d = IDX_ONE;
            j_d = IDX_ZERO;
          end else if (i_q != len_a_q) begin
            i_d = i_q + IDX_ONE;
          end else begin
            state_d = S_READ;
            i_d     = IDX_ONE;
            j_d     = IDX_ONE;
            rd_d    = RD_ZERO;
          end
        end
        S_READ: begin
          if (rd_q != RD_LAST) begin
            rd_d = rd_q + RD_ONE;
          end else if (bus.calculated) begin
            state_d = S_FILLING;
          end else begin
            state_d = S_READ;
          end
        end
        S_FILLING: begin
          if ((i_q == len_a_q) && (j_q == len_b_q)) begin
            if (tb_en_q) begin
              state_d = S_TRACE_B;
              i_d     = len_a_q;
              j_d     = len_b_q;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_CHANGE;
          end
        end
        S_CHANGE: begin
          if (j_q != len_b_q) begin
            j_d = j_q + IDX_ONE;
          end else begin
            j_d = IDX_ONE;
            i_d = i_q + IDX_ONE;
          end
          rd_d    = RD_ZERO;
          state_d = S_READ;
        end
        // Matrix edges override the requested move so indices never wrap
        S_TRACE_B: begin
          if ((i_q == IDX_ZERO) && (j_q == IDX_ZERO)) begin
            state_d = S_DONE;
          end else begin
            if (i_q == IDX_ZERO) begin
              j_d = j_q - IDX_ONE;
            end else if (j_q == IDX_ZERO) begin
              i_d = i_q - IDX_ONE;
            end else begin
              case (bus.tb_dir)
                2'b00: begin
                  i_d = i_q - IDX_ONE;
                  j_d = j_q - IDX_ONE;
                end
                2'b01:   i_d = i_q - IDX_ONE;
                2'b10:   j_d = j_q - IDX_ONE;
                default: begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
                end
              endcase
            end
            if ((i_d == IDX_ZERO) && (j_d == IDX_ZERO)) begin
              state_d = S_DONE;
            end else begin
              state_d = state_d;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore decode of the state register
  always_comb begin
    we_s        = 1'b0;
    en_init_s   = 1'b0;
    en_ins_s    = 1'b0;
    en_read_s   = 1'b0;
    en_traceb_s = 1'b0;
    change_s    = 1'b0;
    busy_s      = 1'b1;
    done_s      = 1'b0;
    case (state_q)
      S_INIT: begin
        we_s      = 1'b1;
        en_init_s = 1'b1;
      end
      S_READ:   en_read_s = 1'b1;
      S_CHANGE: begin
        en_read_s = 1'b1;
        change_s  = 1'b1;
      end
      S_FILLING: begin
        we_s     = 1'b1;
        en_ins_s = 1'b1;
      end
      S_TRACE_B: en_traceb_s = 1'b1;
      S_DONE:    done_s      = 1'b1;
      default:   busy_s      = 1'b0;
    endcase
  end

  assign bus.we           = we_s;
  assign bus.en_init      = en_init_s;
  assign bus.en_ins       = en_ins_s;
  assign bus.en_read      = en_read_s;
  assign bus.en_traceB    = en_traceb_s;
  assign bus.change_index = change_s;
  assign bus.busy         = busy_s;
  assign bus.done         = done_s;
  assign bus.err          = err_q;
  assign bus.state        = state_q;
  assign bus.i            = i_q;
  assign bus.j            = j_q;
  assign bus.rd_sel       = rd_q;

endmodule

// File: tb/tb_nw_ctrl_fsm.sv
// Scoreboard bench for nw_ctrl_fsm: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares whenever the FSM is busy or flags err.
module tb_nw_ctrl_fsm;
  localparam int LEN_W  = 4;
  localparam int N_READ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nw_ctrl_fsm_if #(.LEN_W(LEN_W), .N_READ(N_READ)) bus_if ();
  nw_ctrl_fsm #(.LEN_W(LEN_W), .N_READ(N_READ)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  // flags: busy we en_init en_ins en_read en_traceB change_index done err
  typedef struct packed {
    logic [2:0] st;
    logic [3:0] i;
    logic [3:0] j;
    logic [1:0] rd;
    logic [8:0] fl;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [8:0] flags_for(input logic [2:0] st, input logic e);
    logic [8:0] f;
    case (st)
      3'd1:    f = 9'b1_1100_0000;
      3'd2:    f = 9'b1_0001_0000;
      3'd3:    f = 9'b1_0001_0100;
      3'd4:    f = 9'b1_1010_0000;
      3'd5:    f = 9'b1_0000_1000;
      3'd6:    f = 9'b1_0000_0010;
      default: f = 9'b0_0000_0000;
    endcase
    return f | {8'b0, e};
  endfunction

  // Monitor: every cycle the DUT presents activity, compare against the queue head
  always @(negedge clk) begin
    if (rst && (bus_if.busy || bus_if.err)) begin
      obs_t act;
      obs_t ex;
      act = '{st: bus_if.state, i: bus_if.i, j: bus_if.j, rd: bus_if.rd_sel,
              fl: {bus_if.busy, bus_if.we, bus_if.en_init, bus_if.en_ins, bus_if.en_read,
                   bus_if.en_traceB, bus_if.change_index, bus_if.done, bus_if.err}};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got st=%0d i=%0d j=%0d rd=%0d fl=%b, expected nothing",
                 act.st, act.i, act.j, act.rd, act.fl);
      end else begin
        ex = exp_q.pop_front();
        if (act !== ex) begin
          failures++;
          $display("FAIL cycle_outputs got st=%0d i=%0d j=%0d rd=%0d fl=%b, expected st=%0d i=%0d j=%0d rd=%0d fl=%b",
                   act.st, act.i, act.j, act.rd, act.fl, ex.st, ex.i, ex.j, ex.rd, ex.fl);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got %0h expected %0h", name, act, req);
    end
  endtask

  // Queue the expected outputs for the current cycle, then advance one clock
  task automatic cyc(input logic [2:0] st, input logic [3:0] i, input logic [3:0] j,
                     input logic [1:0] rd, input logic e);
    exp_q.push_back('{st: st, i: i, j: j, rd: rd, fl: flags_for(st, e)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start a run and walk INIT; inputs are scrambled after the start edge
  task automatic start_and_init(input logic [3:0] la, input logic [3:0] lb, input logic tbe);
    bus_if.len_a = la;
    bus_if.len_b = lb;
    bus_if.tb_en = tbe;
    bus_if.start = 1'b1;
    idle_cycle();
    bus_if.len_a = 4'd5;
    bus_if.len_b = 4'd1;
    bus_if.tb_en = ~tbe;
    for (int c = 0; c <= int'(lb); c++) begin
      cyc(3'd1, 4'd0, 4'(c), 2'd0, 1'b0);
      bus_if.start = 1'b0;
    end
    for (int r = 1; r <= int'(la); r++) cyc(3'd1, 4'(r), 4'd0, 2'd0, 1'b0);
  endtask

  // READ x4 / FILLING / CHANGE over every cell; ends after the last FILLING
  task automatic fill(input logic [3:0] la, input logic [3:0] lb, input logic stall);
    for (int r = 1; r <= int'(la); r++) begin
      for (int c = 1; c <= int'(lb); c++) begin
        for (int s = 0; s < N_READ; s++) begin
          bus_if.calculated = !(stall && r == 1 && c == 1);
          cyc(3'd2, 4'(r), 4'(c), 2'(s), 1'b0);
        end
        if (stall && r == 1 && c == 1) begin
          bus_if.calculated = 1'b1;
          cyc(3'd2, 4'(r), 4'(c), 2'd3, 1'b0);
        end
        cyc(3'd4, 4'(r), 4'(c), 2'd3, 1'b0);
        if (!(r == int'(la) && c == int'(lb))) cyc(3'd3, 4'(r), 4'(c), 2'd3, 1'b0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired, expected run to finish");
    $fatal(1);
  end

  initial begin
    bus_if.start      = 1'b0;
    bus_if.len_a      = 4'd0;
    bus_if.len_b      = 4'd0;
    bus_if.tb_en      = 1'b0;
    bus_if.calculated = 1'b1;
    bus_if.tb_dir     = 2'b00;
    bus_if.abort      = 1'b0;
    #1;
    check("reset_state", {13'd0, bus_if.state}, 16'd0);
    check("reset_ij_rd", {6'd0, bus_if.i, bus_if.j, bus_if.rd_sel}, 16'd0);
    check("reset_flags", {10'd0, bus_if.busy, bus_if.done, bus_if.err, bus_if.we,
                          bus_if.en_init, bus_if.en_read}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();

    // Zero length: err one cycle, stays IDLE
    bus_if.len_a = 4'd0;
    bus_if.len_b = 4'd3;
    bus_if.start = 1'b1;
    idle_cycle();
    bus_if.start = 1'b0;
    cyc(3'd0, 4'd0, 4'd0, 2'd0, 1'b1);
    idle_cycle();

    // Run A: traceback diag, left, diag
    start_and_init(4'd2, 4'd3, 1'b1);
    fill(4'd2, 4'd3, 1'b0);
    bus_if.tb_dir = 2'b00; cyc(3'd5, 4'd2, 4'd3, 2'd3, 1'b0);
    bus_if.tb_dir = 2'b10; cyc(3'd5, 4'd1, 4'd2, 2'd3, 1'b0);
    bus_if.tb_dir = 2'b00; cyc(3'd5, 4'd1, 4'd1, 2'd3, 1'b0);
    cyc(3'd6, 4'd0, 4'd0, 2'd3, 1'b0);
    idle_cycle();

    // Run B: no traceback, stalled first cell
    start_and_init(4'd2, 4'd3, 1'b0);
    fill(4'd2, 4'd3, 1'b1);
    cyc(3'd6, 4'd2, 4'd3, 2'd3, 1'b0);
    idle_cycle();

    // Run C: illegal direction at the first traceback step
    start_and_init(4'd2, 4'd3, 1'b1);
    fill(4'd2, 4'd3, 1'b0);
    bus_if.tb_dir = 2'b11; cyc(3'd5, 4'd2, 4'd3, 2'd3, 1'b0);
    cyc(3'd6, 4'd2, 4'd3, 2'd3, 1'b1);
    idle_cycle();

    // Run D: up, up, then row 0 forces left despite tb_dir=11
    start_and_init(4'd2, 4'd3, 1'b1);
    fill(4'd2, 4'd3, 1'b0);
    bus_if.tb_dir = 2'b01; cyc(3'd5, 4'd2, 4'd3, 2'd3, 1'b0);
    cyc(3'd5, 4'd1, 4'd3, 2'd3, 1'b0);
    bus_if.tb_dir = 2'b11; cyc(3'd5, 4'd0, 4'd3, 2'd3, 1'b0);
    cyc(3'd5, 4'd0, 4'd2, 2'd3, 1'b0);
    cyc(3'd5, 4'd0, 4'd1, 2'd3, 1'b0);
    cyc(3'd6, 4'd0, 4'd0, 2'd3, 1'b0);
    bus_if.tb_dir = 2'b00;
    idle_cycle();

    // Abort during READ: back to IDLE next edge, no done
    start_and_init(4'd1, 4'd1, 1'b1);
    cyc(3'd2, 4'd1, 4'd1, 2'd0, 1'b0);
    bus_if.abort = 1'b1;
    cyc(3'd2, 4'd1, 4'd1, 2'd1, 1'b0);
    bus_if.abort = 1'b0;
    idle_cycle();
    idle_cycle();

    // Asynchronous reset in the middle of FILLING
    start_and_init(4'd1, 4'd1, 1'b0);
    for (int s = 0; s < N_READ; s++) cyc(3'd2, 4'd1, 4'd1, 2'(s), 1'b0);
    exp_q.push_back('{st: 3'd4, i: 4'd1, j: 4'd1, rd: 2'd3, fl: flags_for(3'd4, 1'b0)});
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_fill_state", {13'd0, bus_if.state}, 16'd0);
    check("rst_fill_we_ins", {14'd0, bus_if.we, bus_if.en_ins}, 16'd0);
    check("rst_fill_ij", {8'd0, bus_if.i, bus_if.j}, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_held_state", {13'd0, bus_if.state}, 16'd0);
    check("rst_held_busy", {15'd0, bus_if.busy}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();
    idle_cycle();

    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
